// File: rtl/sms_clk_rst_seq.sv
// rtl/sms_clk_rst_seq.sv - PLL-lock reset sequencer and phase-aligned Z80/VDP/PSG clock enables
// Releases core_rst_n after lock settles plus a hold window; enables run only in RUN.
module sms_clk_rst_seq #(
  parameter int LOCK_SETTLE = 1024,
  parameter int RST_HOLD    = 64,
  parameter int CPU_DIV     = 15,
  parameter int VDP_DIV     = 10,
  parameter int PSG_DIV     = 16
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic pll_locked,
  input  logic soft_rst,
  input  logic pause,
  output logic core_rst_n,
  output logic ce_cpu,
  output logic ce_vdp,
  output logic ce_psg,
  output logic running
);

  localparam int SW = $clog2(LOCK_SETTLE);
  localparam int HW = $clog2(RST_HOLD);
  localparam int CW = $clog2(CPU_DIV);
  localparam int VW = $clog2(VDP_DIV);
  localparam int PW = $clog2(PSG_DIV);

  localparam logic [SW-1:0] SETTLE_MAX = SW'(LOCK_SETTLE - 1);
  localparam logic [HW-1:0] HOLD_MAX   = HW'(RST_HOLD - 1);
  localparam logic [CW-1:0] CPU_MAX    = CW'(CPU_DIV - 1);
  localparam logic [VW-1:0] VDP_MAX    = VW'(VDP_DIV - 1);
  localparam logic [PW-1:0] PSG_MAX    = PW'(PSG_DIV - 1);

  typedef enum logic [1:0] {
    ST_WAIT_LOCK,
    ST_SETTLE,
    ST_HOLD,
    ST_RUN
  } state_t;

  state_t        state_q, state_d;
  logic          sync1_q, sync1_d;
  logic          lk_s_q, lk_s_d;
  logic [SW-1:0] settle_cnt_q, settle_cnt_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic [CW-1:0] cpu_cnt_q, cpu_cnt_d;
  logic [VW-1:0] vdp_cnt_q, vdp_cnt_d;
  logic [PW-1:0] psg_cnt_q, psg_cnt_d;
  logic          core_rst_n_q, core_rst_n_d;
  logic          running_q, running_d;
  logic          ce_cpu_q, ce_cpu_d;
  logic          ce_vdp_q, ce_vdp_d;
  logic          ce_psg_q, ce_psg_d;

  logic stay_run;
  logic cpu_tick;
  logic vdp_tick;
  logic psg_last;

  always_comb begin
    sync1_d      = pll_locked;
    lk_s_d       = sync1_q;
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    hold_cnt_d   = hold_cnt_q;

    case (state_q)
      ST_WAIT_LOCK: begin
        if (lk_s_q) begin
          state_d      = ST_SETTLE;
          settle_cnt_d = '0;
        end
      end
      ST_SETTLE: begin
        if (!lk_s_q) begin
          state_d = ST_WAIT_LOCK;
        end else if (settle_cnt_q == SETTLE_MAX) begin
          state_d    = ST_HOLD;
          hold_cnt_d = '0;
        end else begin
          settle_cnt_d = settle_cnt_q + SW'(1);
        end
      end
      ST_HOLD: begin
        if (!lk_s_q) begin
          state_d = ST_WAIT_LOCK;
        end else if (hold_cnt_q == HOLD_MAX) begin
          state_d = ST_RUN;
        end else begin
          hold_cnt_d = hold_cnt_q + HW'(1);
        end
      end
      ST_RUN: begin
        // Lock loss wins over a simultaneous soft reset request.
        if (!lk_s_q) begin
          state_d = ST_WAIT_LOCK;
        end else if (soft_rst) begin
          state_d    = ST_HOLD;
          hold_cnt_d = '0;
        end
      end
      default: state_d = ST_WAIT_LOCK;
    endcase
  end

  // Dividers only advance while RUN persists, so any exit zeroes phase and kills the enables.
  always_comb begin
    stay_run = (state_q == ST_RUN) && (state_d == ST_RUN);
    cpu_tick = (cpu_cnt_q == CPU_MAX);
    vdp_tick = (vdp_cnt_q == VDP_MAX);
    psg_last = (psg_cnt_q == PSG_MAX);

    cpu_cnt_d = '0;
    vdp_cnt_d = '0;
    psg_cnt_d = '0;
    if (stay_run) begin
      cpu_cnt_d = cpu_tick ? '0 : cpu_cnt_q + CW'(1);
      vdp_cnt_d = vdp_tick ? '0 : vdp_cnt_q + VW'(1);
      psg_cnt_d = psg_cnt_q;
      if (cpu_tick) begin
        psg_cnt_d = psg_last ? '0 : psg_cnt_q + PW'(1);
      end
    end

    ce_cpu_d     = stay_run && cpu_tick && !pause;
    ce_vdp_d     = stay_run && vdp_tick;
    ce_psg_d     = stay_run && cpu_tick && psg_last && !pause;
    core_rst_n_d = (state_d == ST_RUN);
    running_d    = (state_d == ST_RUN);
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q      <= ST_WAIT_LOCK;
      sync1_q      <= 1'b0;
      lk_s_q       <= 1'b0;
      settle_cnt_q <= '0;
      hold_cnt_q   <= '0;
      cpu_cnt_q    <= '0;
      vdp_cnt_q    <= '0;
      psg_cnt_q    <= '0;
      core_rst_n_q <= 1'b0;
      running_q    <= 1'b0;
      ce_cpu_q     <= 1'b0;
      ce_vdp_q     <= 1'b0;
      ce_psg_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= sync1_d;
      lk_s_q       <= lk_s_d;
      settle_cnt_q <= settle_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      cpu_cnt_q    <= cpu_cnt_d;
      vdp_cnt_q    <= vdp_cnt_d;
      psg_cnt_q    <= psg_cnt_d;
      core_rst_n_q <= core_rst_n_d;
      running_q    <= running_d;
      ce_cpu_q     <= ce_cpu_d;
      ce_vdp_q     <= ce_vdp_d;
      ce_psg_q     <= ce_psg_d;
    end
  end

  assign core_rst_n = core_rst_n_q;
  assign running    = running_q;
  assign ce_cpu     = ce_cpu_q;
  assign ce_vdp     = ce_vdp_q;
  assign ce_psg     = ce_psg_q;

endmodule

// File: tb/tb_sms_clk_rst_seq.sv
// tb/tb_sms_clk_rst_seq.sv - scoreboard bench for sms_clk_rst_seq against an edge-count reference model
module tb_sms_clk_rst_seq;

  localparam int LOCK_SETTLE = 1024;
  localparam int RST_HOLD    = 64;
  localparam int CPU_DIV     = 15;
  localparam int VDP_DIV     = 10;
  localparam int PSG_DIV     = 16;
  localparam int WAIT_FULL   = 1 + LOCK_SETTLE + RST_HOLD;
  localparam int PWR_LAT     = 2 + LOCK_SETTLE + RST_HOLD + 1;

  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;
  logic pll_locked = 1'b0;
  logic soft_rst = 1'b0;
  logic pause = 1'b0;
  logic core_rst_n, ce_cpu, ce_vdp, ce_psg, running;

  int checks = 0;
  int fails  = 0;

  logic [4:0] exp_q[$];
  logic [4:0] mon_e;

  // Reference model: lock delay line plus "lock-high edges still needed" and age since RUN entry.
  bit m_p1 = 1'b0;
  bit m_p2 = 1'b0;
  bit m_run = 1'b0;
  int m_wait = WAIT_FULL;
  int m_age = 0;

  sms_clk_rst_seq #(
    .LOCK_SETTLE(LOCK_SETTLE),
    .RST_HOLD(RST_HOLD),
    .CPU_DIV(CPU_DIV),
    .VDP_DIV(VDP_DIV),
    .PSG_DIV(PSG_DIV)
  ) dut (
    .clk_sys(clk_sys),
    .reset_n(reset_n),
    .pll_locked(pll_locked),
    .soft_rst(soft_rst),
    .pause(pause),
    .core_rst_n(core_rst_n),
    .ce_cpu(ce_cpu),
    .ce_vdp(ce_vdp),
    .ce_psg(ce_psg),
    .running(running)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic model_edge(input bit rn, input bit lk, input bit sf, input bit ps,
                            output logic [4:0] e);
    bit lk_s;
    e = '0;
    if (!rn) begin
      m_p1 = 1'b0;
      m_p2 = 1'b0;
      m_run = 1'b0;
      m_wait = WAIT_FULL;
      m_age = 0;
    end else begin
      lk_s = m_p2;
      m_p2 = m_p1;
      m_p1 = lk;
      if (!lk_s) begin
        m_run = 1'b0;
        m_wait = WAIT_FULL;
      end else if (m_run) begin
        if (sf) begin
          m_run = 1'b0;
          m_wait = RST_HOLD;
        end else begin
          m_age++;
        end
      end else begin
        m_wait--;
        if (m_wait == 0) begin
          m_run = 1'b1;
          m_age = 0;
        end
      end
      if (m_run) begin
        e[4] = 1'b1;
        e[3] = 1'b1;
        if (m_age > 0) begin
          e[2] = (m_age % CPU_DIV == 0) && !ps;
          e[1] = (m_age % VDP_DIV == 0);
          e[0] = (m_age % (CPU_DIV * PSG_DIV) == 0) && !ps;
        end
      end
    end
  endtask

  task automatic step(input bit rn, input bit lk, input bit sf, input bit ps);
    logic [4:0] e;
    reset_n = rn;
    pll_locked = lk;
    soft_rst = sf;
    pause = ps;
    model_edge(rn, lk, sf, ps, e);
    @(posedge clk_sys);
    #1;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic wait_rise(input string name, input int expv);
    int n;
    n = -1;
    for (int i = 1; i <= 3000 && n < 0; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0);
      if (core_rst_n === 1'b1) n = i;
    end
    chk(name, n, expv);
  endtask

  always @(negedge clk_sys) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      checks++;
      if ({core_rst_n, running, ce_cpu, ce_vdp, ce_psg} !== mon_e) begin
        fails++;
        $display("FAIL scoreboard @%0t: got rst/run/cpu/vdp/psg=%b expected %b",
                 $time, {core_rst_n, running, ce_cpu, ce_vdp, ce_psg}, mon_e);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_cpu, n_vdp, n_psg, n_co, first_co, psg_at, first_cpu, first_vdp, n_high;

    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("reset_outputs", int'({core_rst_n, running, ce_cpu, ce_vdp, ce_psg}), 0);
    wait_rise("powerup_latency", PWR_LAT);
    chk("powerup_running", int'(running), 1);

    n_cpu = 0; n_vdp = 0; n_psg = 0; n_co = 0; first_co = -1; psg_at = -1;
    for (int i = 1; i <= 240; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0);
      n_cpu += int'(ce_cpu);
      n_vdp += int'(ce_vdp);
      n_psg += int'(ce_psg);
      if (ce_cpu && ce_vdp) begin
        n_co++;
        if (first_co < 0) first_co = i;
      end
      if (ce_psg && ce_cpu) psg_at = i;
    end
    chk("cadence_cpu", n_cpu, 16);
    chk("cadence_vdp", n_vdp, 24);
    chk("cadence_psg", n_psg, 1);
    chk("cadence_coincide", n_co, 8);
    chk("cadence_first_coincide", first_co, 30);
    chk("psg_on_16th_cpu", psg_at, 240);

    n_cpu = 0; n_vdp = 0; first_cpu = -1;
    for (int i = 1; i <= 90; i++) begin
      step(1'b1, 1'b1, 1'b0, i <= 45);
      n_cpu += int'(ce_cpu);
      n_vdp += int'(ce_vdp);
      if (i > 45 && ce_cpu && first_cpu < 0) first_cpu = i;
    end
    chk("pause_cpu", n_cpu, 3);
    chk("pause_vdp", n_vdp, 9);
    chk("pause_grid", first_cpu, 60);

    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("soft_drop", int'(core_rst_n), 0);
    wait_rise("soft_hold_len", RST_HOLD);
    first_cpu = -1; first_vdp = -1;
    for (int i = 1; i <= 20; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0);
      if (ce_cpu && first_cpu < 0) first_cpu = i;
      if (ce_vdp && first_vdp < 0) first_vdp = i;
    end
    chk("soft_restart_cpu", first_cpu, CPU_DIV);
    chk("soft_restart_vdp", first_vdp, VDP_DIV);

    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("lockloss_still_up", int'(core_rst_n), 1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("lockloss_down", int'({core_rst_n, running, ce_cpu, ce_vdp, ce_psg}), 0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 503; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    wait_rise("relock_after_glitch", PWR_LAT);

    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    n_high = 0;
    for (int i = 0; i < 100; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0);
      n_high += int'(core_rst_n);
    end
    chk("simul_no_early_release", n_high, 0);
    wait_rise("simul_full_settle", WAIT_FULL - 100);

    step(1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("reset_in_hold", int'({core_rst_n, running, ce_cpu, ce_vdp, ce_psg}), 0);
    wait_rise("after_hold_reset", PWR_LAT);

    for (int i = 0; i < 4000; i++) begin
      step(($urandom % 2500) != 0, ($urandom % 1500) != 0,
           ($urandom % 300) == 0, ($urandom % 4) == 0);
    end
    step(1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk_sys);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
